// File: rtl/and_gate_sched_pkg.sv
// Shared types and constants for the RSFQ and_gate scheduler.
package and_gate_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETUP,
    S_CLOCK,
    S_CAPTURE,
    S_DONE,
    S_HOLD
  } state_t;

  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_RESP_CYC  = 4;
  localparam int unsigned DEF_HOLD_CYC  = 2;

  // Counter must hold the largest load: setup, response, or the reset drain (resp + hold).
  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned r,
                                            input int unsigned h);
    int unsigned m;
    m = s;
    if (r > m) m = r;
    if (h + r > m) m = h + r;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  int unsigned     j;
  logic [IW-1:0]   jj;

  always_comb begin
    grant_oh = '0;
    idx      = '0;
    vld      = 1'b0;
    j        = 0;
    jj       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!vld && req[jj]) begin
        vld          = 1'b1;
        idx          = jj;
        grant_oh[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_gate_scheduler.sv
// Shares one RSFQ and_gate among NREQ requesters: operand pulses, setup wait,
// gate clock, response capture, result return, then a hold gap.
module and_gate_scheduler
  import and_gate_sched_pkg::*;
#(
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned RESP_CYC  = DEF_RESP_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  localparam int unsigned IW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a_bit,
  input  logic [NREQ-1:0] b_bit,
  output logic [NREQ-1:0] grant,
  output logic            done,
  output logic [IW-1:0]   done_id,
  output logic            result,
  output logic            mismatch,
  output logic            gate_a,
  output logic            gate_b,
  output logic            gate_clk,
  input  logic            gate_out
);

  localparam int unsigned CW = cnt_width(SETUP_CYC, RESP_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] RESP_LD  = CW'(RESP_CYC);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] DRAIN_LD = CW'(RESP_CYC + HOLD_CYC);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id;
  logic            op_a;
  logic            op_b;
  logic            seen;
  logic            seen_nx;
  logic            last_cnt;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant_oh (pick_oh),
    .idx      (pick_idx),
    .vld      (pick_vld)
  );

  assign seen_nx  = seen | gate_out;
  assign last_cnt = (cnt <= CW'(1));

  // Reset parks in HOLD so any stale gate pulse drains out before the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_HOLD;
      cnt      <= DRAIN_LD;
      ptr      <= '0;
      id       <= '0;
      op_a     <= 1'b0;
      op_b     <= 1'b0;
      seen     <= 1'b0;
      grant    <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      result   <= 1'b0;
      mismatch <= 1'b0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      gate_clk <= 1'b0;
    end else begin
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      gate_clk <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            id     <= pick_idx;
            op_a   <= a_bit[pick_idx];
            op_b   <= b_bit[pick_idx];
            grant  <= pick_oh;
            gate_a <= a_bit[pick_idx];
            gate_b <= b_bit[pick_idx];
            state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          cnt   <= SETUP_LD;
          state <= S_SETUP;
        end
        S_SETUP: begin
          cnt <= (cnt != '0) ? cnt - 1'b1 : '0;
          if (last_cnt) begin
            gate_clk <= 1'b1;
            state    <= S_CLOCK;
          end
        end
        S_CLOCK: begin
          seen  <= 1'b0;
          cnt   <= RESP_LD;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          seen <= seen_nx;
          cnt  <= (cnt != '0) ? cnt - 1'b1 : '0;
          if (last_cnt) begin
            done     <= 1'b1;
            done_id  <= id;
            result   <= seen_nx;
            mismatch <= seen_nx ^ (op_a & op_b);
            ptr      <= (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          grant <= '0;
          cnt   <= HOLD_LD;
          state <= (HOLD_CYC == 0) ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          cnt <= (cnt != '0) ? cnt - 1'b1 : '0;
          if (last_cnt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_scheduler.sv
// Randomized bench for and_gate_scheduler with a behavioural RSFQ gate and a
// transaction-level round-robin reference.
module tb_and_gate_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int S = 2;
  localparam int R = 4;
  localparam int H = 2;
  localparam int GOOD   = 0;
  localparam int SILENT = 1;
  localparam int FAULTY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] a_bit = '0;
  logic [3:0] b_bit = '0;
  logic [3:0] grant;
  logic       done;
  logic [1:0] done_id;
  logic       result, mismatch, gate_a, gate_b, gate_clk;
  logic       gate_out = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  and_gate_scheduler #(.NREQ(NREQ), .SETUP_CYC(S), .RESP_CYC(R), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bit(a_bit), .b_bit(b_bit),
    .grant(grant), .done(done), .done_id(done_id), .result(result), .mismatch(mismatch),
    .gate_a(gate_a), .gate_b(gate_b), .gate_clk(gate_clk), .gate_out(gate_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural gate: remembers a/b pulses, on clk emits one pulse gdly cycles later.
  int gmode = GOOD;
  int gdly = 1;
  int pend = 0;
  bit ma = 0, mb = 0, stray = 0;

  always @(negedge clk) begin
    gate_out = stray;
    if (rst) begin
      ma = 0; mb = 0; pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) gate_out = 1'b1;
      end
      if (gate_a) ma = 1;
      if (gate_b) mb = 1;
      if (gate_clk) begin
        if (gmode == FAULTY || (gmode == GOOD && ma && mb)) pend = gdly;
        ma = 0; mb = 0;
      end
    end
  end

  // Output monitor
  int n_a = 0, n_b = 0, n_clk = 0, n_done = 0, bad_grant = 0;
  int a_cyc = 0, clk_cyc = 0, d_cyc = 0;
  int d_id = 0;
  bit d_res = 0, d_mis = 0;

  always @(negedge clk) begin
    if (gate_a) begin n_a++; a_cyc = cyc; end
    if (gate_b) n_b++;
    if (gate_clk) begin n_clk++; clk_cyc = cyc; end
    if (done) begin n_done++; d_cyc = cyc; d_id = int'(done_id); d_res = result; d_mis = mismatch; end
    if (grant != 4'b0 && !$onehot(grant)) bad_grant++;
  end

  int ptr_m = 0;

  function automatic int rr_pick(input logic [3:0] rq, input int p);
    for (int i = 0; i < 4; i++)
      if (rq[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int nd0, output bit ok);
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (n_done != nd0) ok = 1;
    end
    if (!ok) check("done_timeout", n_done, nd0 + 1);
  endtask

  task automatic do_reset(output int r0);
    rst = 1'b1; req = '0; a_bit = '0; b_bit = '0;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_result", result, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_gate_pulses", {gate_a, gate_b, gate_clk}, 0);
    rst = 1'b0;
    r0 = cyc;
    ptr_m = 0;
  endtask

  task automatic do_op(input logic [3:0] rq, input logic [3:0] av, input logic [3:0] bv,
                       input int md, input bit chk_lat, input bit drop, input bit stray_hold);
    int id_e, na0, nb0, nc0, nd0, c0;
    bit ok, seen_clk;
    logic re, me, ab;
    id_e = rr_pick(rq, ptr_m);
    ab = av[id_e] & bv[id_e];
    re = (md == GOOD) ? ab : (md == FAULTY);
    me = re ^ ab;
    na0 = n_a; nb0 = n_b; nc0 = n_clk; nd0 = n_done;
    gmode = md;
    gdly = $urandom_range(1, R);
    req = rq; a_bit = av; b_bit = bv;
    c0 = cyc;
    if (drop) begin
      seen_clk = 0;
      for (int i = 0; i < 40 && !seen_clk; i++) begin
        tick();
        if (n_clk != nc0) seen_clk = 1;
      end
      tick();
      req = '0; a_bit = ~av; b_bit = ~bv;
    end
    wait_done(nd0, ok);
    if (ok) begin
      check("done_id", d_id, id_e);
      check("result", d_res, re);
      check("mismatch", d_mis, me);
      check("grant_at_done", grant, 32'(1) << id_e);
      check("gate_a_count", n_a - na0, av[id_e]);
      check("gate_b_count", n_b - nb0, bv[id_e]);
      check("gate_clk_count", n_clk - nc0, 1);
      check("clk_to_done", d_cyc - clk_cyc, R + 1);
      if (chk_lat) begin
        if (av[id_e]) check("lat_gate_a", a_cyc, c0 + 1);
        check("lat_gate_clk", clk_cyc, c0 + 2 + S);
        check("lat_done", d_cyc, c0 + 3 + S + R);
      end
      ptr_m = (id_e + 1) % 4;
    end
    if (!drop) begin
      req = '0; a_bit = 4'($urandom); b_bit = 4'($urandom);
    end
    stray = stray_hold;
    for (int i = 0; i < H + 1; i++) begin
      tick();
      stray = 0;
      if (i == 0) begin
        check("done_one_cycle", done, 0);
        check("result_hold", result, re);
      end
    end
  endtask

  task automatic b2b();
    logic [3:0] av, bv;
    int id_e, nd0, prev;
    bit ok;
    av = 4'($urandom); bv = 4'($urandom);
    gmode = GOOD; gdly = 2; prev = 0;
    req = 4'hF; a_bit = av; b_bit = bv;
    for (int k = 0; k < 5; k++) begin
      nd0 = n_done;
      wait_done(nd0, ok);
      if (!ok) break;
      id_e = rr_pick(4'hF, ptr_m);
      check("b2b_id", d_id, id_e);
      check("b2b_result", d_res, av[id_e] & bv[id_e]);
      check("b2b_mismatch", d_mis, 0);
      if (k > 0) check("b2b_spacing", d_cyc - prev, 4 + S + R + H);
      prev = d_cyc;
      ptr_m = (id_e + 1) % 4;
    end
    req = '0;
    repeat (H + 1) tick();
  endtask

  initial begin
    int r0, na0, nd0;
    bit got;
    do_reset(r0);
    repeat (R + H) tick();

    do_op(4'b0001, 4'b0001, 4'b0001, GOOD,   1, 0, 0);
    do_op(4'b0010, 4'b0010, 4'b0000, SILENT, 1, 0, 0);
    do_op(4'b1000, 4'b0000, 4'b0000, FAULTY, 1, 0, 1);
    do_op(4'b1000, 4'b1000, 4'b1000, SILENT, 1, 0, 0);
    do_op(4'b0100, 4'b0100, 4'b0100, GOOD,   1, 1, 0);
    do_op(4'b0101, 4'b1111, 4'b1111, GOOD,   1, 0, 0);

    for (int n = 0; n < 24; n++)
      do_op(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom),
            $urandom_range(0, 2), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Abort during SETUP, then check the drain delay before the next operand pulse.
    gmode = GOOD;
    na0 = n_a; nd0 = n_done;
    req = 4'b0001; a_bit = 4'b0001; b_bit = 4'b0001;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (n_a != na0) got = 1;
    end
    check("abort_saw_drive", got, 1);
    tick();
    rst = 1'b1;
    #1;
    check("abort_grant", grant, 0);
    check("abort_gate_pulses", {gate_a, gate_b, gate_clk}, 0);
    check("abort_done", done, 0);
    tick(); tick();
    rst = 1'b0;
    r0 = cyc;
    ptr_m = 0;
    do_op(4'b0010, 4'b0010, 4'b0010, GOOD, 0, 0, 0);
    check("drain_before_gate_a", (a_cyc - r0) >= (R + H + 1), 1);
    check("abort_no_done", n_done - nd0, 1);

    do_reset(r0);
    repeat (R + H) tick();
    b2b();
    check("grant_onehot", bad_grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
